sdram_frame_writer: RTL and testbench
=====================================

// Module: sdram_frame_writer
// PURPOSE
//  Avalon-MM burst write master into the HPS f2h_sdram port. Pairs with sdram_reader: it fills frame buffers that the reader streams out.
//  Accepts a 256-bit Avalon-ST pixel-word stream, buffers it in an internal show-ahead FIFO and writes exactly one frame per start command.
//  Issues fixed-length gap-free bursts at consecutive word addresses, starting at a latched base address. FPGA_CLK1_50 domain.
// PARAMETERS
//  SDRAM_DATA_WIDTH  256     data width; byteenable width = SDRAM_DATA_WIDTH/8
//  SDRAM_ADDR_WIDTH  27      word address width (one address = one data word)
//  BURST_LEN         8       beats per burst; power of 2, 1..128
//  FRAME_WORDS       194400  words per frame (1920x1080x24bpp/256); must be a multiple of BURST_LEN
//  FIFO_DEPTH        32      input FIFO entries; power of 2, >= 2*BURST_LEN
// PORTS
//  clk                 in   1     system clock
//  rst                 in   1     synchronous, active-high reset
//  frame_start_i       in   1     1-cycle pulse: begin a frame (honoured only in IDLE)
//  base_addr_i         in   27    frame base word address, latched on accepted start
//  st_data_i           in   256   stream word
//  st_valid_i          in   1     stream word valid
//  st_ready_o          out  1     stream word accepted when st_valid_i && st_ready_o
//  sdram_address_o     out  27    burst start word address
//  sdram_burstcount_o  out  8     burst length (= BURST_LEN)
//  sdram_writedata_o   out  256   write beat data
//  sdram_byteenable_o  out  32    byte enables, all ones
//  sdram_write_o       out  1     write request
//  sdram_waitrequest_i in   1     slave stall
//  busy_o              out  1     high from accepted start until frame_done_o
//  frame_done_o        out  1     1-cycle pulse after the last beat is accepted
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO flushed, beat/word counters=0. Outputs: st_ready_o=0, sdram_write_o=0, busy_o=0, frame_done_o=0,
//    sdram_address_o=0, sdram_writedata_o=0. sdram_burstcount_o=BURST_LEN and sdram_byteenable_o all ones (constants).
//  A reset mid-burst drops the write immediately. No completion of the partial burst is attempted.
//  st_ready_o = busy_o && !fifo_full && (words_in < FRAME_WORDS).
//    Words arriving before start, or beyond FRAME_WORDS, are not accepted.
//  Beat acceptance: sdram_write_o && !sdram_waitrequest_i. While stalled, address, data and write are held stable.
//  FSM:
//    IDLE  : on frame_start_i, latch base_addr_i into addr, clear counters, set busy_o -> FILL.
//    FILL  : when fifo_count >= BURST_LEN -> BURST (sdram_write_o=1 next cycle, address=addr).
//    BURST : write high on every beat (FIFO guarantees no gaps); pop FIFO per accepted beat.
//            After the BURST_LEN-th beat: addr += BURST_LEN (mod 2^27, wraps silently);
//            words_out += BURST_LEN; -> DONE if words_out==FRAME_WORDS, else -> FILL.
//    DONE  : frame_done_o=1 for one cycle, busy_o=0 -> IDLE.
//  Boundaries:
//    FIFO push and pop in the same cycle: count unchanged.
//    Full FIFO: ready low, no overwrite.
//    frame_start_i while busy: ignored.
//    frame_start_i in the DONE cycle: ignored. It is honoured one cycle later, in IDLE.
//  Latencies:
//    start pulse -> st_ready_o high: 1 cycle.
//    BURST_LEN-th word accepted into FIFO -> sdram_write_o: <= 2 cycles.
// CONFIGURATION
//  SDRAM_WRITER_STALL_CNT_EN defined:
//    Adds port stall_cnt_o (out, 32), a saturating count of cycles with sdram_write_o && sdram_waitrequest_i.
//    Cleared on accepted start and on rst. Holds its value after frame_done_o.
//  Not defined: port and counter absent; all other behaviour identical.
// TESTING (bench: BURST_LEN=4, FRAME_WORDS=16, FIFO_DEPTH=8)
//  1. Start with base 0x100, 16 words, waitrequest=0 -> bursts at 0x100/0x104/0x108/0x10C, data in order, one frame_done_o pulse.
//  2. Waitrequest random 50% -> data, address and write stable during stall; all 16 beats written once; stall_cnt_o matches the stalled-cycle count (macro on).
//  3. Source valid before start; sink stalled with 8 words queued -> st_ready_o=0 both times, no FIFO overwrite.
//  4. Base 0x7FFFFFC -> second burst address 0x0000000 (wrap).
//  5. rst asserted on beat 2 of burst 1 -> next cycle: write=0, busy_o=0; a new start then completes a full 16-word frame correctly.
//  6. frame_start_i pulsed mid-frame and in the DONE cycle -> ignored; frame_done_o pulses exactly once.

Source files
------------

// File: rtl/sdram_frame_writer.sv
// Avalon-MM burst write master: buffers a pixel-word stream and writes one frame per start command.
// Optional stall counter port enabled by defining SDRAM_WRITER_STALL_CNT_EN.
module sdram_frame_writer #(
    parameter int unsigned SDRAM_DATA_WIDTH = 256,
    parameter int unsigned SDRAM_ADDR_WIDTH = 27,
    parameter int unsigned BURST_LEN        = 8,
    parameter int unsigned FRAME_WORDS      = 194400,
    parameter int unsigned FIFO_DEPTH       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start_i,
    input  logic [SDRAM_ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [SDRAM_DATA_WIDTH-1:0]   st_data_i,
    input  logic                          st_valid_i,
    output logic                          st_ready_o,
    output logic [SDRAM_ADDR_WIDTH-1:0]   sdram_address_o,
    output logic [7:0]                    sdram_burstcount_o,
    output logic [SDRAM_DATA_WIDTH-1:0]   sdram_writedata_o,
    output logic [SDRAM_DATA_WIDTH/8-1:0] sdram_byteenable_o,
    output logic                          sdram_write_o,
    input  logic                          sdram_waitrequest_i,
    output logic                          busy_o,
    output logic                          frame_done_o
`ifdef SDRAM_WRITER_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cnt_o
`endif
);

    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned WordW = $clog2(FRAME_WORDS + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    localparam logic [BeatW-1:0]            LastBeat   = BeatW'(BURST_LEN - 1);
    localparam logic [WordW-1:0]            FrameWords = WordW'(FRAME_WORDS);
    localparam logic [WordW-1:0]            BurstWords = WordW'(BURST_LEN);
    localparam logic [WordW-1:0]            FrameLast  = WordW'(FRAME_WORDS - BURST_LEN);
    localparam logic [CntW-1:0]             FifoFull   = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0]             BurstCnt   = CntW'(BURST_LEN);
    localparam logic [SDRAM_ADDR_WIDTH-1:0] AddrStep   = SDRAM_ADDR_WIDTH'(BURST_LEN);

    typedef enum logic [1:0] {StIdle, StFill, StBurst, StDone} state_e;

    state_e state_q, state_d;

    logic [SDRAM_ADDR_WIDTH-1:0] addr_q;
    logic [BeatW-1:0]            beat_q;
    logic [WordW-1:0]            words_in_q;
    logic [WordW-1:0]            words_out_q;

    logic [SDRAM_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q;
    logic [PtrW-1:0]             rd_ptr_q;
    logic [CntW-1:0]             fifo_cnt_q;

    logic start_acc;
    logic push;
    logic pop;
    logic burst_end;

    assign start_acc = (state_q == StIdle) && frame_start_i;
    assign push      = st_valid_i && st_ready_o;
    assign pop       = sdram_write_o && !sdram_waitrequest_i;
    assign burst_end = pop && (beat_q == LastBeat);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (frame_start_i) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                // A full burst is already buffered, so write can stay high for every beat
                if (fifo_cnt_q >= BurstCnt) begin
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (burst_end) begin
                    state_d = (words_out_q == FrameLast) ? StDone : StFill;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o        = 1'b0;
        sdram_write_o = 1'b0;
        frame_done_o  = 1'b0;
        case (state_q)
            StFill: begin
                busy_o = 1'b1;
            end
            StBurst: begin
                busy_o        = 1'b1;
                sdram_write_o = 1'b1;
            end
            StDone: begin
                frame_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign st_ready_o = busy_o && (fifo_cnt_q != FifoFull) && (words_in_q < FrameWords);

    assign sdram_address_o    = addr_q;
    assign sdram_burstcount_o = 8'(BURST_LEN);
    assign sdram_byteenable_o = '1;
    // Head is only meaningful while writing; keep the bus quiet otherwise
    assign sdram_writedata_o  = sdram_write_o ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            beat_q      <= '0;
            words_in_q  <= '0;
            words_out_q <= '0;
        end else if (start_acc) begin
            addr_q      <= base_addr_i;
            beat_q      <= '0;
            words_in_q  <= '0;
            words_out_q <= '0;
        end else begin
            if (push) begin
                words_in_q <= words_in_q + 1'b1;
            end
            if (pop) begin
                if (beat_q == LastBeat) begin
                    beat_q      <= '0;
                    addr_q      <= addr_q + AddrStep;
                    words_out_q <= words_out_q + BurstWords;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    // Show-ahead FIFO; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= st_data_i;
        end
    end

`ifdef SDRAM_WRITER_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            stall_cnt_q <= '0;
        end else if (sdram_write_o && sdram_waitrequest_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Self-checking bench for sdram_frame_writer (BURST_LEN=4, FRAME_WORDS=16, FIFO_DEPTH=8).
// Stall counter checks are active when SDRAM_WRITER_STALL_CNT_EN is defined.
module tb_sdram_frame_writer;

    localparam int AW = 27;
    localparam int DW = 256;
    localparam int BL = 4;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [AW-1:0] sdram_address;
    logic [7:0]    sdram_burstcount;
    logic [DW-1:0] sdram_writedata;
    logic [31:0]   sdram_byteenable;
    logic          sdram_write;
    logic          sdram_waitrequest = 1'b0;
    logic          busy;
    logic          frame_done;
`ifdef SDRAM_WRITER_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    sdram_frame_writer #(
        .SDRAM_DATA_WIDTH(DW),
        .SDRAM_ADDR_WIDTH(AW),
        .BURST_LEN       (BL),
        .FRAME_WORDS     (FW),
        .FIFO_DEPTH      (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_start_i      (frame_start),
        .base_addr_i        (base_addr),
        .st_data_i          (st_data),
        .st_valid_i         (st_valid),
        .st_ready_o         (st_ready),
        .sdram_address_o    (sdram_address),
        .sdram_burstcount_o (sdram_burstcount),
        .sdram_writedata_o  (sdram_writedata),
        .sdram_byteenable_o (sdram_byteenable),
        .sdram_write_o      (sdram_write),
        .sdram_waitrequest_i(sdram_waitrequest),
        .busy_o             (busy),
        .frame_done_o       (frame_done)
`ifdef SDRAM_WRITER_STALL_CNT_EN
        ,
        .stall_cnt_o        (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus queue and expected frame contents
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];

    // Bus observations
    logic [AW-1:0] mon_addr[$];
    logic [DW-1:0] mon_data[$];
    int            mon_stalls = 0;
    int            mon_acc    = 0;
    int            stall_viol = 0;
    int            done_cnt   = 0;

    bit force_wait = 1'b0;
    bit rand_wait  = 1'b0;

    // Slave waitrequest driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            sdram_waitrequest = force_wait | (rand_wait & ($urandom_range(0, 1) == 1));
        end
    end

    // Stream source: pops a word once the DUT has taken it
    initial begin
        bit fire;
        forever begin
            @(negedge clk);
            fire = st_valid && st_ready && !rst;
            @(posedge clk);
            #1;
            if (fire && src_q.size() > 0) void'(src_q.pop_front());
            st_valid = (src_q.size() > 0);
            if (src_q.size() > 0) st_data = src_q[0];
        end
    end

    // Bus monitor
    initial begin
        bit            prev_stall = 1'b0;
        logic [AW-1:0] prev_addr  = '0;
        logic [DW-1:0] prev_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !(sdram_write && sdram_address == prev_addr &&
                                    sdram_writedata == prev_data)) stall_viol++;
                if (sdram_write && !sdram_waitrequest) begin
                    mon_addr.push_back(sdram_address);
                    mon_data.push_back(sdram_writedata);
                end
                if (sdram_write && sdram_waitrequest) mon_stalls++;
                if (frame_done) done_cnt++;
                if (st_valid && st_ready) mon_acc++;
                prev_stall = sdram_write && sdram_waitrequest;
                prev_addr  = sdram_address;
                prev_data  = sdram_writedata;
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_words();
        logic [DW-1:0] w;
        exp_q.delete();
        for (int i = 0; i < FW; i++) begin
            for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
            exp_q.push_back(w);
            src_q.push_back(w);
        end
    endtask

    task automatic start_pulse(input logic [AW-1:0] b);
        mon_addr.delete();
        mon_data.delete();
        mon_stalls  = 0;
        mon_acc     = 0;
        stall_viol  = 0;
        frame_start = 1'b1;
        base_addr   = b;
        tick();
        frame_start = 1'b0;
        chk("start_busy", DW'(busy), DW'(1));
        chk("start_ready", DW'(st_ready), DW'(1));
    endtask

    task automatic wait_done(input int target);
        for (int n = 0; n < 1000 && done_cnt < target; n++) tick();
        chk("done_in_time", DW'(done_cnt >= target), DW'(1));
    endtask

    task automatic check_frame(input logic [AW-1:0] b);
        logic [AW-1:0] ea;
        chk("beat_count", DW'(mon_addr.size()), DW'(FW));
        for (int i = 0; i < FW && i < mon_addr.size(); i++) begin
            ea = b + AW'(BL * (i / BL));
            chk($sformatf("addr%0d", i), DW'(mon_addr[i]), DW'(ea));
            chk($sformatf("data%0d", i), mon_data[i], exp_q[i]);
        end
        chk("stall_stable", DW'(stall_viol), DW'(0));
    endtask

    task automatic run_frame(input logic [AW-1:0] b);
        int d0;
        d0 = done_cnt;
        load_words();
        start_pulse(b);
        wait_done(d0 + 1);
        tick();
        tick();
        chk("one_done", DW'(done_cnt - d0), DW'(1));
        chk("idle_busy", DW'(busy), DW'(0));
        chk("idle_write", DW'(sdram_write), DW'(0));
        check_frame(b);
    endtask

    initial begin
        int d0;

        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_ready", DW'(st_ready), DW'(0));
        chk("rst_write", DW'(sdram_write), DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(frame_done), DW'(0));
        chk("rst_addr", DW'(sdram_address), DW'(0));
        chk("rst_wdata", sdram_writedata, DW'(0));
        chk("burstcount", DW'(sdram_burstcount), DW'(BL));
        chk("byteenable", DW'(sdram_byteenable), DW'(32'hFFFF_FFFF));
        rst = 1'b0;
        tick();

        // 1: plain frame
        run_frame(AW'('h100));

        // 2: random stalls
        rand_wait = 1'b1;
        run_frame(AW'('h2000));
        rand_wait = 1'b0;
`ifdef SDRAM_WRITER_STALL_CNT_EN
        chk("stall_cnt", DW'(stall_cnt), DW'(mon_stalls));
        tick(); tick(); tick();
        chk("stall_cnt_hold", DW'(stall_cnt), DW'(mon_stalls));
`endif

        // 3: source valid before start, sink stalled until the FIFO fills
        load_words();
        tick(); tick(); tick();
        chk("pre_start_ready", DW'(st_ready), DW'(0));
        force_wait = 1'b1;
        d0 = done_cnt;
        start_pulse(AW'('h300));
        for (int n = 0; n < 20; n++) tick();
        chk("full_accepted", DW'(mon_acc), DW'(8));
        chk("full_ready", DW'(st_ready), DW'(0));
        force_wait = 1'b0;
        wait_done(d0 + 1);
        tick();
        check_frame(AW'('h300));

        // 4: address wrap
        run_frame(AW'('h7FF_FFFC));

        // 5: reset on beat 2 of burst 1
        load_words();
        start_pulse(AW'('h500));
        for (int n = 0; n < 100 && mon_addr.size() < 1; n++) tick();
        chk("beat2_on_bus", DW'(sdram_write), DW'(1));
        rst = 1'b1;
        tick();
        chk("rst_mid_write", DW'(sdram_write), DW'(0));
        chk("rst_mid_busy", DW'(busy), DW'(0));
        rst = 1'b0;
        src_q.delete();
        tick();
        run_frame(AW'('h600));

        // 6: starts while busy and in the DONE cycle are ignored
        d0 = done_cnt;
        load_words();
        start_pulse(AW'('h700));
        for (int n = 0; n < 5; n++) tick();
        frame_start = 1'b1;
        base_addr   = AW'('h999);
        tick();
        frame_start = 1'b0;
        for (int n = 0; n < 1000 && !frame_done; n++) tick();
        chk("saw_done", DW'(frame_done), DW'(1));
        frame_start = 1'b1;
        base_addr   = AW'('hABC);
        tick();
        frame_start = 1'b0;
        chk("done_start_ignored", DW'(busy), DW'(0));
        tick(); tick();
        chk("single_done", DW'(done_cnt - d0), DW'(1));
        check_frame(AW'('h700));
        run_frame(AW'('h800));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
